// File: rtl/dither_pkg.sv
// Shared constants and types for the dithered frame pipeline.
// Frame geometry, pixel bundle and frame-reader state encoding.
package dither_pkg;

    localparam int IMAGEX     = 64;
    localparam int IMAGEY     = 64;
    localparam int RGB_SIZE   = 8;
    localparam int IMAGE_SIZE = IMAGEX * IMAGEY;
    localparam int ADDR_W     = $clog2(IMAGE_SIZE);
    localparam int X_W        = $clog2(IMAGEX);

    typedef struct packed {
        logic [RGB_SIZE-1:0] red;
        logic [RGB_SIZE-1:0] green;
        logic [RGB_SIZE-1:0] blue;
    } pixel_t;

    typedef struct packed {
        pixel_t pix;
        logic   sof;
        logic   eol;
        logic   eof;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } reader_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO of output beats with a registered head entry.
// Ports: clk, rst (async active-low), push/din, pop, head, full, empty, count.
module pixel_skid_fifo
    import dither_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BEAT_W-1:0] din,
    input  logic              pop,
    output logic [BEAT_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [BEAT_W-1:0] head_q, head_d;
    logic [BEAT_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop;

    // Head holds its last value when the FIFO drains, so the
    // output data stays stable while out_valid is low.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = din;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && do_pop) begin
                    head_d = din;
                end else if (push) begin
                    tail_d  = din;
                    count_d = 2'd2;
                end else if (do_pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (do_pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = din;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/dither_frame_reader.sv
// Streams the 64x64 dithered frame from the RGB buffer in raster order.
// Ports: start/busy/done control, sync read port (mem_rd_*), valid/ready
// pixel stream with sof/eol/eof sideband; clk, rst (async active-low).
module dither_frame_reader
    import dither_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [RGB_SIZE-1:0] mem_rd_red,
    input  logic [RGB_SIZE-1:0] mem_rd_green,
    input  logic [RGB_SIZE-1:0] mem_rd_blue,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RGB_SIZE-1:0] out_red,
    output logic [RGB_SIZE-1:0] out_green,
    output logic [RGB_SIZE-1:0] out_blue,
    output logic                out_sof,
    output logic                out_eol,
    output logic                out_eof
);

    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(IMAGE_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(IMAGEX - 1);

    reader_state_t   state_q, state_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] beat_cnt_q, beat_cnt_d;
    logic            inflight_q, inflight_d;

    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_count;
    logic [BEAT_W-1:0] fifo_head;
    logic [2:0]        occ;
    logic              issue, pop;
    logic [ADDR_W-1:0] push_addr;
    beat_t             push_beat, head_beat;

    assign pop = !fifo_empty && out_ready;

    // Credit counts the slot freed by this cycle's pop, which is what
    // lets a read issue every cycle while the sink keeps up.
    assign occ   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue = (state_q == STREAM) && !fifo_full && (occ < 3'd2);

    // At most one read is in flight; it is the one before rd_ptr.
    assign push_addr       = rd_ptr_q[ADDR_W-1:0] - ADDR_W'(1);
    assign push_beat.pix   = '{mem_rd_red, mem_rd_green, mem_rd_blue};
    assign push_beat.sof   = (push_addr == '0);
    assign push_beat.eol   = (push_addr[X_W-1:0] == LAST_X);
    assign push_beat.eof   = (push_addr == LAST_ADDR);

    pixel_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   (push_beat),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        inflight_d = issue;
        if (pop) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = STREAM;
                    rd_ptr_d   = '0;
                    beat_cnt_d = '0;
                end
            end
            STREAM: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (beat_cnt_q == LAST_CNT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign head_beat   = fifo_head;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_ptr_q[ADDR_W-1:0];
    assign out_valid   = !fifo_empty;
    assign out_red     = head_beat.pix.red;
    assign out_green   = head_beat.pix.green;
    assign out_blue    = head_beat.pix.blue;
    assign out_sof     = head_beat.sof;
    assign out_eol     = head_beat.eol;
    assign out_eof     = head_beat.eof;

endmodule
